axist_gpio_csr: RTL and testbench

//  Avalon-MM responder (CSR slave) for the AXI-ST GPIO test system, on the management clock.

---
 rtl/axist_gpio_csr_pkg.sv | 26 ++
 rtl/axist_gpio_csr_if.sv | 20 ++
 rtl/axist_gpio_csr_rdmux.sv | 20 ++
 rtl/axist_gpio_csr.sv | 228 ++++++++++++++++++++++
 tb/tb_axist_gpio_csr.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axist_gpio_csr_pkg.sv
// Shared definitions for the AXI-ST GPIO CSR block: register offsets, word-count helper, FSM states.
package axist_gpio_csr_pkg;

    localparam logic [15:0] OFF_TX_PKT_CTRL = 16'h1000;
    localparam logic [15:0] OFF_RX_CKR_STS  = 16'h1004;
    localparam logic [15:0] OFF_LINKUP_STS  = 16'h1008;
    localparam logic [15:0] OFF_DELAY_X     = 16'h2000;
    localparam logic [15:0] OFF_DELAY_Y     = 16'h2004;
    localparam logic [15:0] OFF_DELAY_Z     = 16'h2008;
    localparam logic [15:0] OFF_AXI_CTRL    = 16'h3000;
    // Capture windows occupy 0x4000-0x43FF, 0x100 bytes per capture
    localparam logic [5:0]  CAP_WIN_TAG     = 6'b010000;

    typedef enum logic [2:0] {
        IDLE,
        WR_ACK,
        RD_WAIT,
        RD_RESP,
        HOLD
    } csr_state_e;

    function automatic int nwords(input int factor);
        return 2 * factor;
    endfunction

endpackage

// File: rtl/axist_gpio_csr_if.sv
// Avalon-MM CSR bus between the management master and the GPIO CSR responder.
interface axist_gpio_csr_if;
    logic [31:0] i_wr_addr;
    logic [31:0] i_wrdata;
    logic        i_wren;
    logic        i_rden;
    logic [31:0] o_master_readdata;
    logic        o_master_readdatavalid;
    logic        o_master_waitreq;

    modport master (
        output i_wr_addr, i_wrdata, i_wren, i_rden,
        input  o_master_readdata, o_master_readdatavalid, o_master_waitreq
    );

    modport slave (
        input  i_wr_addr, i_wrdata, i_wren, i_rden,
        output o_master_readdata, o_master_readdatavalid, o_master_waitreq
    );
endinterface

// File: rtl/axist_gpio_csr_rdmux.sv
// Selects one 32-bit word out of a TDW-bit capture; words at or beyond NW read as zero.
module axist_gpio_csr_rdmux #(
    parameter int TDW = 256,
    parameter int NW  = 8
) (
    input  logic [TDW-1:0] i_cap,
    input  logic [5:0]     i_word,
    output logic [31:0]    o_data
);

    always_comb begin
        o_data = '0;
        for (int k = 0; k < NW; k++) begin
            if (int'(i_word) == k) begin
                o_data = i_cap[32*k +: 32];
            end
        end
    end

endmodule

// File: rtl/axist_gpio_csr.sv
// Avalon-MM CSR responder for the AXI-ST GPIO test system (mgmt_clk domain).
// Optional AXIST_CSR_SNAPSHOT_EN: a word-0 capture read freezes all captures for coherent multi-word reads.
module axist_gpio_csr
    import axist_gpio_csr_pkg::*;
#(
    parameter int          AXI_TDATA_FACTOR = 4,
    parameter logic [31:0] BASE_ADDR        = 32'h5000_0000,
    parameter int          RD_LATENCY       = 2
) (
    input  logic                          mgmt_clk,
    input  logic                          rst_n,
    axist_gpio_csr_if.slave               io_avmm,
    input  logic [3:0]                    i_linkup_sts,
    input  logic [3:0]                    i_ckr_sts,
    input  logic [64*AXI_TDATA_FACTOR-1:0] i_dout_first,
    input  logic [64*AXI_TDATA_FACTOR-1:0] i_dout_last,
    input  logic [64*AXI_TDATA_FACTOR-1:0] i_din_first,
    input  logic [64*AXI_TDATA_FACTOR-1:0] i_din_last,
    output logic [31:0]                   o_delay_x,
    output logic [31:0]                   o_delay_y,
    output logic [31:0]                   o_delay_z,
    output logic                          o_axi_rst,
    output logic [31:0]                   o_tx_pkt_ctrl,
    output logic                          o_pkt_start
);

    localparam int         TDW    = 64 * AXI_TDATA_FACTOR;
    localparam int         NWORDS = nwords(AXI_TDATA_FACTOR);
    localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);
    localparam logic       LAT_ONE = (RD_LATENCY <= 1);

    csr_state_e  r_state;
    logic [2:0]  r_cnt;
    logic [29:0] r_addr;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_waitreq;
    logic        r_pkt_start;
    logic [31:0] r_tx_pkt_ctrl;
    logic [31:0] r_delay_x;
    logic [31:0] r_delay_y;
    logic [31:0] r_delay_z;
    logic        r_axi_rst;

    logic           w_wr_acc;
    logic           w_rd_acc;
    logic           w_rd_load;
    logic           w_wr_hit;
    logic [15:0]    w_wr_off;
    logic           w_pkt_go;
    logic [29:0]    w_rd_word;
    logic           w_rd_hit;
    logic [15:0]    w_rd_off;
    logic [31:0]    w_rdata;
    logic [TDW-1:0] w_cap_live [4];
    logic [TDW-1:0] w_cap_src  [4];
    logic [31:0]    w_cap_word [4];

    assign w_wr_acc  = (r_state == IDLE) && io_avmm.i_wren;
    assign w_rd_acc  = (r_state == IDLE) && !io_avmm.i_wren && io_avmm.i_rden;
    assign w_rd_load = (w_rd_acc && LAT_ONE) || ((r_state == RD_WAIT) && (r_cnt <= 3'd1));

    assign w_wr_hit = (io_avmm.i_wr_addr[31:16] == BASE_ADDR[31:16]);
    assign w_wr_off = {io_avmm.i_wr_addr[15:2], 2'b00};
    assign w_pkt_go = w_wr_acc && w_wr_hit && (w_wr_off == OFF_TX_PKT_CTRL) && io_avmm.i_wrdata[0];

    // Only a single-cycle latency read decodes the live bus; otherwise the latched address is used
    assign w_rd_word = (r_state == IDLE) ? io_avmm.i_wr_addr[31:2] : r_addr;
    assign w_rd_hit  = (w_rd_word[29:14] == BASE_ADDR[31:16]);
    assign w_rd_off  = {w_rd_word[13:0], 2'b00};

    assign w_cap_live[0] = i_dout_first;
    assign w_cap_live[1] = i_dout_last;
    assign w_cap_live[2] = i_din_first;
    assign w_cap_live[3] = i_din_last;

`ifdef AXIST_CSR_SNAPSHOT_EN
    logic [TDW-1:0] r_shadow [4];
    logic           w_snap;

    assign w_snap = w_rd_load && w_rd_hit && (w_rd_off[15:10] == CAP_WIN_TAG) && (w_rd_off[7:2] == 6'd0);

    always_ff @(posedge mgmt_clk) begin
        if (w_snap) begin
            for (int j = 0; j < 4; j++) begin
                r_shadow[j] <= w_cap_live[j];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_cap_src[j] = (w_rd_off[7:2] == 6'd0) ? w_cap_live[j] : r_shadow[j];
        end
    end
`else
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_cap_src[j] = w_cap_live[j];
        end
    end
`endif

    for (genvar g = 0; g < 4; g++) begin : g_rdmux
        axist_gpio_csr_rdmux #(
            .TDW (TDW),
            .NW  (NWORDS)
        ) u_rdmux (
            .i_cap  (w_cap_src[g]),
            .i_word (w_rd_off[7:2]),
            .o_data (w_cap_word[g])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd_hit) begin
            case (w_rd_off)
                OFF_TX_PKT_CTRL: w_rdata = r_tx_pkt_ctrl;
                OFF_RX_CKR_STS:  w_rdata = {28'b0, i_ckr_sts};
                OFF_LINKUP_STS:  w_rdata = {28'b0, i_linkup_sts};
                OFF_DELAY_X:     w_rdata = r_delay_x;
                OFF_DELAY_Y:     w_rdata = r_delay_y;
                OFF_DELAY_Z:     w_rdata = r_delay_z;
                OFF_AXI_CTRL:    w_rdata = {31'b0, r_axi_rst};
                default: begin
                    if (w_rd_off[15:10] == CAP_WIN_TAG) begin
                        w_rdata = w_cap_word[w_rd_off[9:8]];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge mgmt_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_pkt_ctrl <= '0;
            r_delay_x     <= '0;
            r_delay_y     <= '0;
            r_delay_z     <= '0;
            r_axi_rst     <= 1'b0;
        end else if (w_wr_acc && w_wr_hit) begin
            case (w_wr_off)
                OFF_TX_PKT_CTRL: r_tx_pkt_ctrl <= io_avmm.i_wrdata;
                OFF_DELAY_X:     r_delay_x     <= io_avmm.i_wrdata;
                OFF_DELAY_Y:     r_delay_y     <= io_avmm.i_wrdata;
                OFF_DELAY_Z:     r_delay_z     <= io_avmm.i_wrdata;
                OFF_AXI_CTRL:    r_axi_rst     <= io_avmm.i_wrdata[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge mgmt_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_waitreq   <= 1'b1;
            r_pkt_start <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wr_acc) begin
                        r_state     <= WR_ACK;
                        r_waitreq   <= 1'b0;
                        r_pkt_start <= w_pkt_go;
                    end else if (w_rd_acc) begin
                        r_addr <= io_avmm.i_wr_addr[31:2];
                        r_cnt  <= LAT_M1;
                        if (w_rd_load) begin
                            r_state   <= RD_RESP;
                            r_rvalid  <= 1'b1;
                            r_waitreq <= 1'b0;
                            r_rdata   <= w_rdata;
                        end else begin
                            r_state <= RD_WAIT;
                        end
                    end
                end
                WR_ACK: begin
                    r_state     <= HOLD;
                    r_waitreq   <= 1'b1;
                    r_pkt_start <= 1'b0;
                end
                RD_WAIT: begin
                    if (w_rd_load) begin
                        r_state   <= RD_RESP;
                        r_rvalid  <= 1'b1;
                        r_waitreq <= 1'b0;
                        r_rdata   <= w_rdata;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RD_RESP: begin
                    r_state   <= HOLD;
                    r_rvalid  <= 1'b0;
                    r_waitreq <= 1'b1;
                end
                HOLD: begin
                    // A request still held after its completion must not be served twice
                    if (!io_avmm.i_wren && !io_avmm.i_rden) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_rvalid  <= 1'b0;
                    r_waitreq <= 1'b1;
                end
            endcase
        end
    end

    assign io_avmm.o_master_readdata      = r_rdata;
    assign io_avmm.o_master_readdatavalid = r_rvalid;
    assign io_avmm.o_master_waitreq       = r_waitreq;
    assign o_delay_x     = r_delay_x;
    assign o_delay_y     = r_delay_y;
    assign o_delay_z     = r_delay_z;
    assign o_axi_rst     = r_axi_rst;
    assign o_tx_pkt_ctrl = r_tx_pkt_ctrl;
    assign o_pkt_start   = r_pkt_start;

endmodule

// File: tb/tb_axist_gpio_csr.sv
// Self-checking bench for axist_gpio_csr: directed vector table, corner-case sequences, random ops vs a model.
module tb_axist_gpio_csr;

    localparam int TDW = 256;
    localparam int NW  = 8;
    localparam int RDL = 2;

    logic mgmt_clk = 1'b0;
    logic rst_n    = 1'b0;
    always #5 mgmt_clk = ~mgmt_clk;

    axist_gpio_csr_if avmm ();

    logic [3:0]     linkup, ckr;
    logic [TDW-1:0] dout_f, dout_l, din_f, din_l;
    logic [31:0]    dx, dy, dz, tx;
    logic           axi_rst, pkt_start;

    axist_gpio_csr #(
        .AXI_TDATA_FACTOR (4),
        .BASE_ADDR        (32'h5000_0000),
        .RD_LATENCY       (RDL)
    ) dut (
        .mgmt_clk      (mgmt_clk),
        .rst_n         (rst_n),
        .io_avmm       (avmm.slave),
        .i_linkup_sts  (linkup),
        .i_ckr_sts     (ckr),
        .i_dout_first  (dout_f),
        .i_dout_last   (dout_l),
        .i_din_first   (din_f),
        .i_din_last    (din_l),
        .o_delay_x     (dx),
        .o_delay_y     (dy),
        .o_delay_z     (dz),
        .o_axi_rst     (axi_rst),
        .o_tx_pkt_ctrl (tx),
        .o_pkt_start   (pkt_start)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Reference register file, indexed by the register's meaning rather than any encoding
    logic [31:0] m_tx, m_dx, m_dy, m_dz;
    logic        m_axi;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int off, cap, k;
        if (a[31:16] != 16'h5000) return 32'h0;
        off = int'(a[15:0]) & 32'hFFFC;
        if (off == 'h1000) return m_tx;
        if (off == 'h1004) return {28'b0, ckr};
        if (off == 'h1008) return {28'b0, linkup};
        if (off == 'h2000) return m_dx;
        if (off == 'h2004) return m_dy;
        if (off == 'h2008) return m_dz;
        if (off == 'h3000) return {31'b0, m_axi};
        if (off >= 'h4000 && off < 'h4400) begin
            cap = (off - 'h4000) / 'h100;
            k   = (off % 'h100) / 4;
            if (k >= NW) return 32'h0;
            if (cap == 0) return dout_f[k*32 +: 32];
            if (cap == 1) return dout_l[k*32 +: 32];
            if (cap == 2) return din_f[k*32 +: 32];
            return din_l[k*32 +: 32];
        end
        return 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        int off;
        if (a[31:16] != 16'h5000) return;
        off = int'(a[15:0]) & 32'hFFFC;
        if (off == 'h1000) m_tx = d;
        if (off == 'h2000) m_dx = d;
        if (off == 'h2004) m_dy = d;
        if (off == 'h2008) m_dz = d;
        if (off == 'h3000) m_axi = d[0];
    endtask

    function automatic logic model_pulse(input logic [31:0] a, input logic [31:0] d);
        return (a[31:16] == 16'h5000) && ((a[15:0] & 16'hFFFC) == 16'h1000) && d[0];
    endfunction

    task automatic model_reset();
        m_tx = 0; m_dx = 0; m_dy = 0; m_dz = 0; m_axi = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_delay_x"}, dx, m_dx);
        chk({tag, "_delay_y"}, dy, m_dy);
        chk({tag, "_delay_z"}, dz, m_dz);
        chk({tag, "_tx_pkt_ctrl"}, tx, m_tx);
        chk({tag, "_axi_rst"}, {31'b0, axi_rst}, {31'b0, m_axi});
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic pulse);
        int n;
        avmm.i_wr_addr = a;
        avmm.i_wrdata  = d;
        avmm.i_wren    = 1'b1;
        n = 0;
        do begin
            @(negedge mgmt_clk);
            n++;
        end while (avmm.o_master_waitreq && n < 32);
        chk("wr_ack_seen", {31'b0, avmm.o_master_waitreq}, 32'h0);
        pulse = pkt_start;
        avmm.i_wren = 1'b0;
        @(negedge mgmt_clk);
        chk("wr_pulse_width", {31'b0, pkt_start}, 32'h0);
        chk("wr_hold_waitreq", {31'b0, avmm.o_master_waitreq}, 32'h1);
        @(negedge mgmt_clk);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        avmm.i_wr_addr = a;
        avmm.i_rden    = 1'b1;
        lat = 0;
        do begin
            @(negedge mgmt_clk);
            lat++;
        end while (!avmm.o_master_readdatavalid && lat < 32);
        chk("rd_valid_seen", {31'b0, avmm.o_master_readdatavalid}, 32'h1);
        chk("rd_resp_waitreq", {31'b0, avmm.o_master_waitreq}, 32'h0);
        d = avmm.o_master_readdata;
        avmm.i_rden = 1'b0;
        @(negedge mgmt_clk);
        chk("rd_valid_width", {30'b0, avmm.o_master_readdatavalid, avmm.o_master_waitreq}, 32'h1);
        @(negedge mgmt_clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int s;
        s = $urandom_range(0, 9);
        case (s)
            0: a = 32'h5000_1000;
            1: a = 32'h5000_1004;
            2: a = 32'h5000_1008;
            3: a = 32'h5000_2000;
            4: a = 32'h5000_2004;
            5: a = 32'h5000_2008;
            6: a = 32'h5000_3000;
            7: a = 32'h5000_4000 + 32'($urandom_range(0, 3)) * 32'h100 + 32'($urandom_range(0, 11)) * 4;
            8: a = {16'h5000, 16'($urandom)};
            default: a = $urandom();
        endcase
        a[1:0] = 2'($urandom);
        return a;
    endfunction

    task automatic rand_status();
        linkup = 4'($urandom);
        ckr    = 4'($urandom);
        for (int i = 0; i < NW; i++) begin
            dout_f[i*32 +: 32] = $urandom();
            dout_l[i*32 +: 32] = $urandom();
            din_f[i*32 +: 32]  = $urandom();
            din_l[i*32 +: 32]  = $urandom();
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;   // read data, or expected pkt_start for writes
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd2, a, d;
        logic        pl;
        int          lat;

        avmm.i_wr_addr = '0;
        avmm.i_wrdata  = '0;
        avmm.i_wren    = 1'b0;
        avmm.i_rden    = 1'b0;
        linkup = 4'b0101;
        ckr    = 4'b1011;
        for (int i = 0; i < 32; i++) dout_f[i*8 +: 8] = 8'(i);
        dout_l = '1;
        din_f  = {8{32'hA5A5_0000}};
        din_l  = '0;
        model_reset();

        repeat (3) @(negedge mgmt_clk);
        chk("rst_waitreq", {31'b0, avmm.o_master_waitreq}, 32'h1);
        chk("rst_rvalid", {31'b0, avmm.o_master_readdatavalid}, 32'h0);
        chk("rst_readdata", avmm.o_master_readdata, 32'h0);
        chk("rst_pkt_start", {31'b0, pkt_start}, 32'h0);
        chk_outputs("rst");
        rst_n = 1'b1;
        @(negedge mgmt_clk);

        tbl.push_back('{1'b1, 32'h5000_2008, 32'h0000_1770, 32'h0});
        tbl.push_back('{1'b0, 32'h5000_2008, 32'h0,         32'h0000_1770});
        tbl.push_back('{1'b1, 32'h5000_1000, 32'h0000_0FF5, 32'h1});
        tbl.push_back('{1'b1, 32'h5000_1000, 32'h0000_0FF4, 32'h0});
        tbl.push_back('{1'b0, 32'h5000_1000, 32'h0,         32'h0000_0FF4});
        tbl.push_back('{1'b0, 32'h5000_1004, 32'h0,         32'h0000_000B});
        tbl.push_back('{1'b0, 32'h5000_1008, 32'h0,         32'h0000_0005});
        tbl.push_back('{1'b0, 32'h5000_4000, 32'h0,         32'h0302_0100});
        tbl.push_back('{1'b0, 32'h5000_4004, 32'h0,         32'h0706_0504});
        tbl.push_back('{1'b0, 32'h5000_401C, 32'h0,         32'h1F1E_1D1C});
        tbl.push_back('{1'b0, 32'h5000_4020, 32'h0,         32'h0});
        tbl.push_back('{1'b0, 32'h5000_4104, 32'h0,         32'hFFFF_FFFF});
        tbl.push_back('{1'b0, 32'h5000_4218, 32'h0,         32'hA5A5_0000});
        tbl.push_back('{1'b0, 32'h5000_6000, 32'h0,         32'h0});
        tbl.push_back('{1'b0, 32'h6000_1000, 32'h0,         32'h0});
        tbl.push_back('{1'b1, 32'h5000_3000, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{1'b0, 32'h5000_3000, 32'h0,         32'h0000_0001});
        tbl.push_back('{1'b1, 32'h6000_2008, 32'h0000_DEAD, 32'h0});
        tbl.push_back('{1'b1, 32'h5000_6000, 32'h0000_BEEF, 32'h0});
        tbl.push_back('{1'b1, 32'h5000_1004, 32'h0000_1234, 32'h0});
        tbl.push_back('{1'b0, 32'h5000_1004, 32'h0,         32'h0000_000B});
        tbl.push_back('{1'b0, 32'h5000_200B, 32'h0,         32'h0000_1770});
        tbl.push_back('{1'b1, 32'h5000_2001, 32'h1234_5678, 32'h0});
        tbl.push_back('{1'b0, 32'h5000_2000, 32'h0,         32'h1234_5678});

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].addr, tbl[i].data, pl);
                model_write(tbl[i].addr, tbl[i].data);
                chk($sformatf("vec%0d_pulse", i), {31'b0, pl}, tbl[i].exp);
            end else begin
                bus_read(tbl[i].addr, rd, lat);
                chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
                chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(RDL));
            end
        end
        chk_outputs("vec");
        chk("vec_delay_z", dz, 32'h0000_1770);
        chk("vec_tx_pkt", tx, 32'h0000_0FF4);

        // readdata must hold across a write
        bus_read(32'h5000_1008, rd, lat);
        bus_write(32'h5000_2004, 32'h0000_0042, pl);
        model_write(32'h5000_2004, 32'h0000_0042);
        chk("rdata_hold", avmm.o_master_readdata, 32'h0000_0005);

        // address change while a read is in flight uses the latched address
        avmm.i_wr_addr = 32'h5000_2008;
        avmm.i_rden    = 1'b1;
        @(negedge mgmt_clk);
        avmm.i_wr_addr = 32'h5000_2000;
        @(negedge mgmt_clk);
        chk("inflight_valid", {31'b0, avmm.o_master_readdatavalid}, 32'h1);
        chk("inflight_addr", avmm.o_master_readdata, 32'h0000_1770);
        avmm.i_rden = 1'b0;
        repeat (2) @(negedge mgmt_clk);

        // simultaneous write and read: write first, held request served once
        avmm.i_wr_addr = 32'h5000_2000;
        avmm.i_wrdata  = 32'h0000_A5A5;
        avmm.i_wren    = 1'b1;
        avmm.i_rden    = 1'b1;
        lat = 0;
        do begin
            @(negedge mgmt_clk);
            lat++;
        end while (avmm.o_master_waitreq && lat < 32);
        chk("both_wr_ack", {30'b0, avmm.o_master_readdatavalid, avmm.o_master_waitreq}, 32'h0);
        model_write(32'h5000_2000, 32'h0000_A5A5);
        for (int i = 0; i < 5; i++) begin
            @(negedge mgmt_clk);
            chk($sformatf("both_hold%0d", i), {30'b0, avmm.o_master_readdatavalid, avmm.o_master_waitreq}, 32'h1);
        end
        chk("both_delay_x", dx, 32'h0000_A5A5);
        avmm.i_wren = 1'b0;
        avmm.i_rden = 1'b0;
        repeat (2) @(negedge mgmt_clk);
        bus_read(32'h5000_2000, rd, lat);
        chk("both_readback", rd, 32'h0000_A5A5);

        // random operations against the model
        for (int it = 0; it < 300; it++) begin
            if (it % 16 == 0) rand_status();
            a = rand_addr();
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom();
                if ($urandom_range(0, 3) == 0) d[0] = 1'b1;
                bus_write(a, d, pl);
                chk($sformatf("rnd%0d_pulse", it), {31'b0, pl}, {31'b0, model_pulse(a, d)});
                model_write(a, d);
                chk_outputs($sformatf("rnd%0d", it));
            end else begin
                rd2 = model_read(a);
                bus_read(a, rd, lat);
                chk($sformatf("rnd%0d_rd_%h", it, a), rd, rd2);
            end
        end

        // reset asserted during RD_WAIT aborts the read
        bus_write(32'h5000_2004, 32'h0000_0077, pl);
        model_write(32'h5000_2004, 32'h0000_0077);
        avmm.i_wr_addr = 32'h5000_2004;
        avmm.i_rden    = 1'b1;
        @(negedge mgmt_clk);
        rst_n = 1'b0;
        #1;
        chk("abort_waitreq", {31'b0, avmm.o_master_waitreq}, 32'h1);
        chk("abort_readdata", avmm.o_master_readdata, 32'h0);
        model_reset();
        chk_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge mgmt_clk);
            chk($sformatf("abort_novalid%0d", i), {31'b0, avmm.o_master_readdatavalid}, 32'h0);
        end
        avmm.i_rden = 1'b0;
        rst_n = 1'b1;
        @(negedge mgmt_clk);
        chk("abort_idle_waitreq", {31'b0, avmm.o_master_waitreq}, 32'h1);
        bus_read(32'h5000_2004, rd, lat);
        chk("abort_reg_cleared", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
